// File: rtl/mvm_seq_ctrl.sv
// mvm_seq_ctrl: sequencer for an NxN matrix-vector multiply (y = A*x).
//
// Streams the x vector and then the row-major A matrix into external memories
// under in_valid/in_ready. It then schedules one MAC pass per row and writes each
// finished dot product into the y memory. Finally it streams y out under
// out_valid/out_ready and pulses done.
//
// The external memories have a registered read, so data appears one cycle after
// the address. The MAC is registered: clear_acc forces f to 0, otherwise f
// accumulates a*x.
//
// Build option: define MVM_X_REUSE_EN to add the reuse_x input. When reuse_x is
// sampled high with start, the job skips the x load and reuses the x vector
// already held in memory.
//
// N must be at least 2.

module mvm_seq_ctrl #(
    parameter int N = 4,
    localparam int AXW = $clog2(N),
    localparam int AAW = $clog2(N * N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
`ifdef MVM_X_REUSE_EN
    input  logic           reuse_x,
`endif
    input  logic           in_valid,
    output logic           in_ready,
    output logic [AXW-1:0] addr_x,
    output logic           wr_en_x,
    output logic [AAW-1:0] addr_a,
    output logic           wr_en_a,
    output logic           clear_acc,
    output logic [AXW-1:0] addr_y,
    output logic           wr_en_y,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           busy,
    output logic           done
);

    // Column counter: it runs 0..N-1 while addresses are issued, and N is the
    // drain cycle.
    localparam int CW = $clog2(N + 1);

    localparam logic [AXW-1:0] X_LAST   = AXW'(N - 1);
    localparam logic [AAW-1:0] K_X_LAST = AAW'(N - 1);
    localparam logic [AAW-1:0] K_A_LAST = AAW'(N * N - 1);
    localparam logic [CW-1:0]  C_GAP    = CW'(N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_X,
        S_LOAD_A,
        S_COMPUTE,
        S_OUTPUT
    } state_t;

    state_t         state_q, state_d;
    logic [AAW-1:0] k_q, k_d;            // load word index (x, then A)
    logic [AXW-1:0] r_q, r_d;            // compute row
    logic [CW-1:0]  c_q, c_d;            // cycle within the current row
    logic           wb_q, wb_d;          // final writeback cycle of COMPUTE
    logic [AXW-1:0] i_q, i_d;            // output word index
    logic           out_valid_q, out_valid_d;
    logic           done_q, done_d;

    // State and counter registers; reset aborts any job in flight at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            r_q         <= '0;
            c_q         <= '0;
            wb_q        <= 1'b0;
            i_q         <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge
            // values, so the order of these lines does not matter.
            state_q     <= state_d;
            k_q         <= k_d;
            r_q         <= r_d;
            c_q         <= c_d;
            wb_q        <= wb_d;
            i_q         <= i_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    // Next-state, counter updates and memory/MAC control for the current phase.
    always_comb begin
        // NOTE: every signal gets a default value before the case statement, so
        // no path can leave one unassigned and infer a latch.
        state_d     = state_q;
        k_d         = k_q;
        r_d         = r_q;
        c_d         = c_q;
        wb_d        = wb_q;
        i_d         = i_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;

        in_ready    = 1'b0;
        addr_x      = '0;
        wr_en_x     = 1'b0;
        addr_a      = '0;
        wr_en_a     = 1'b0;
        clear_acc   = 1'b0;
        addr_y      = '0;
        wr_en_y     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    k_d = '0;
`ifdef MVM_X_REUSE_EN
                    state_d = reuse_x ? S_LOAD_A : S_LOAD_X;
`else
                    state_d = S_LOAD_X;
`endif
                end
            end

            S_LOAD_X: begin
                // data_in goes straight to the memory; we only steer the write.
                in_ready = 1'b1;
                wr_en_x  = in_valid;
                addr_x   = k_q[AXW-1:0];
                if (in_valid) begin
                    if (k_q == K_X_LAST) begin
                        k_d     = '0;
                        state_d = S_LOAD_A;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end

            S_LOAD_A: begin
                in_ready = 1'b1;
                wr_en_a  = in_valid;
                addr_a   = k_q;
                if (in_valid) begin
                    if (k_q == K_A_LAST) begin
                        k_d     = '0;
                        r_d     = '0;
                        c_d     = '0;
                        wb_d    = 1'b0;
                        state_d = S_COMPUTE;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end

            S_COMPUTE: begin
                if (wb_q) begin
                    // The last row has finished accumulating; store it and move on.
                    wr_en_y     = 1'b1;
                    addr_y      = X_LAST;
                    wb_d        = 1'b0;
                    r_d         = '0;
                    c_d         = '0;
                    i_d         = '0;
                    out_valid_d = 1'b0;
                    state_d     = S_OUTPUT;
                end else begin
                    if (c_q != C_GAP) begin
                        addr_x    = c_q[AXW-1:0];
                        addr_a    = AAW'(r_q) * AAW'(N) + AAW'(c_q);
                        clear_acc = (c_q == '0);
                    end
                    // The y write of the previous row shares a cycle with the
                    // clear. The memory captures f before the clear lands.
                    if (c_q == '0 && r_q != '0) begin
                        wr_en_y = 1'b1;
                        addr_y  = r_q - 1'b1;
                    end
                    if (c_q == C_GAP) begin
                        c_d = '0;
                        if (r_q == X_LAST) begin
                            wb_d = 1'b1;
                        end else begin
                            r_d = r_q + 1'b1;
                        end
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                end
            end

            S_OUTPUT: begin
                // The first cycle at each index is a read bubble. After that,
                // out_valid stays high until the consumer takes the word.
                addr_y = i_q;
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (i_q == X_LAST) begin
                        i_d     = '0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign out_valid = out_valid_q;
    assign done      = done_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mvm_seq_ctrl.sv
// Testbench for mvm_seq_ctrl.
//
// The bench wraps the controller with behavioural x/a/y memories, each with a
// registered read, and with a registered 16-bit wrapping MAC. It drives jobs with
// directed and random data, input gaps and output backpressure. The y words are
// compared against a dot-product model. The bench also checks the phase timing:
// the load handshake, the COMPUTE row schedule, the output bubbles and stalls,
// and the done pulse.
// Define MVM_X_REUSE_EN to exercise the reuse_x option as well.

module tb_mvm_seq_ctrl;
    localparam int N   = 4;
    localparam int AXW = $clog2(N);
    localparam int AAW = $clog2(N * N);

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
`ifdef MVM_X_REUSE_EN
    logic           reuse_x;
`endif
    logic           in_valid;
    logic           in_ready;
    logic [7:0]     data_in;
    logic [AXW-1:0] addr_x;
    logic           wr_en_x;
    logic [AAW-1:0] addr_a;
    logic           wr_en_a;
    logic           clear_acc;
    logic [AXW-1:0] addr_y;
    logic           wr_en_y;
    logic           out_valid;
    logic           out_ready;
    logic           busy;
    logic           done;

    always #5 clk = ~clk;

    mvm_seq_ctrl #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
`ifdef MVM_X_REUSE_EN
        .reuse_x   (reuse_x),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .addr_x    (addr_x),
        .wr_en_x   (wr_en_x),
        .addr_a    (addr_a),
        .wr_en_a   (wr_en_a),
        .clear_acc (clear_acc),
        .addr_y    (addr_y),
        .wr_en_y   (wr_en_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    // Datapath around the controller: the memories and the MAC.
    logic signed [7:0]  x_mem [N];
    logic signed [7:0]  a_mem [N*N];
    logic signed [15:0] y_mem [N];
    logic signed [7:0]  x_dout, a_dout;
    logic signed [15:0] y_dout, f;

    always @(posedge clk) begin
        if (wr_en_x) x_mem[addr_x] <= data_in;
        if (wr_en_a) a_mem[addr_a] <= data_in;
        if (wr_en_y) y_mem[addr_y] <= f;
        x_dout <= x_mem[addr_x];
        a_dout <= a_mem[addr_a];
        y_dout <= y_mem[addr_y];
        if (clear_acc) f <= '0;
        else           f <= f + a_dout * x_dout;
    end

    // Reference model: plain integer vectors and the expected results.
    int xv [N];
    int av [N*N];
    int yexp [N];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int rand_s8();
        byte b;
        b = byte'($urandom);
        return int'(b);
    endfunction

    task automatic compute_expected();
        for (int r = 0; r < N; r++) begin
            int s;
            s = 0;
            for (int c = 0; c < N; c++) s += xv[c] * av[r*N + c];
            yexp[r] = s & 32'hFFFF;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"},  {31'b0, in_ready},  32'd0);
        check({tag, "_wr_en_x"},   {31'b0, wr_en_x},   32'd0);
        check({tag, "_addr_x"},    32'(addr_x),        32'd0);
        check({tag, "_wr_en_a"},   {31'b0, wr_en_a},   32'd0);
        check({tag, "_addr_a"},    32'(addr_a),        32'd0);
        check({tag, "_clear_acc"}, {31'b0, clear_acc}, 32'd0);
        check({tag, "_wr_en_y"},   {31'b0, wr_en_y},   32'd0);
        check({tag, "_addr_y"},    32'(addr_y),        32'd0);
        check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
        check({tag, "_busy"},      {31'b0, busy},      32'd0);
        check({tag, "_done"},      {31'b0, done},      32'd0);
    endtask

    // Runs one job from start to done.
    //   gap_mode: 0 = in_valid always high, 1 = alternating 1,0, 2 = random gaps.
    //   out_mode: 0 = always ready, 1 = three stalled cycles per word, 2 = random.
    //   abort_t:  COMPUTE cycle at which reset is pulsed (-1 = never).
    task automatic run_job(input bit reuse, input int gap_mode, input int out_mode,
                           input int abort_t);
        int  xcount, words, idx, budget, word, wait_cnt, row, col;
        bit  v, rdy, acc, exp_valid, exp_wr;

        compute_expected();
        xcount = reuse ? 0 : N;
        words  = xcount + N * N;

        @(negedge clk);
        start = 1'b1;
`ifdef MVM_X_REUSE_EN
        reuse_x = reuse;
`endif
        #1;
        check("idle_in_ready", {31'b0, in_ready}, 32'd0);
        check("idle_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        start = 1'b0;

        // Load phase: x words first (unless reused), then A in row-major order.
        idx = 0;
        budget = 0;
        while (idx < words && budget < 2000) begin
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (budget % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            in_valid = v;
            data_in  = (idx < xcount) ? 8'(xv[idx]) : 8'(av[idx - xcount]);
            #1;
            check("load_in_ready", {31'b0, in_ready}, 32'd1);
            check("load_busy", {31'b0, busy}, 32'd1);
            if (idx < xcount) begin
                check("load_wr_en_x", {31'b0, wr_en_x}, {31'b0, v});
                check("load_wr_en_a_idle", {31'b0, wr_en_a}, 32'd0);
                check("load_addr_x", 32'(addr_x), 32'(idx));
            end else begin
                check("load_wr_en_a", {31'b0, wr_en_a}, {31'b0, v});
                check("load_wr_en_x_idle", {31'b0, wr_en_x}, 32'd0);
                check("load_addr_a", 32'(addr_a), 32'(idx - xcount));
            end
            if (v && in_ready) idx++;
            budget++;
            @(negedge clk);
        end
        check("load_words", 32'(idx), 32'(words));
        in_valid = 1'b0;

        // COMPUTE: N rows of N+1 cycles, then one writeback cycle.
        // A start pulse during the pass must have no effect.
        for (int t = 0; t <= N * (N + 1); t++) begin
            if (t == abort_t) begin
                reset    = 1'b0;
                in_valid = 1'b1;
                #1;
                check_all_zero("abort");
                @(negedge clk);
                in_valid = 1'b0;
                reset    = 1'b1;
                #1;
                check_all_zero("after_abort");
                return;
            end
            start = (t >= 2 && t < 5);
            #1;
            row    = t / (N + 1);
            col    = t % (N + 1);
            exp_wr = (t > 0) && (col == 0);
            check("cmp_busy", {31'b0, busy}, 32'd1);
            check("cmp_in_ready", {31'b0, in_ready}, 32'd0);
            check("cmp_clear", {31'b0, clear_acc}, {31'b0, (t < N * (N + 1)) && (col == 0)});
            check("cmp_wr_en_y", {31'b0, wr_en_y}, {31'b0, exp_wr});
            if (exp_wr) check("cmp_addr_y", 32'(addr_y), 32'(row - 1));
            if (t < N * (N + 1) && col < N) begin
                check("cmp_addr_a", 32'(addr_a), 32'(row * N + col));
                check("cmp_addr_x", 32'(addr_x), 32'(col));
            end
            @(negedge clk);
        end
        start = 1'b0;

        // OUTPUT: a bubble at each index, then valid until accepted.
        word      = 0;
        wait_cnt  = 0;
        budget    = 0;
        exp_valid = 1'b0;
        while (word < N && budget < 500) begin
            case (out_mode)
                0:       rdy = 1'b1;
                1:       rdy = (wait_cnt >= 3);
                default: rdy = $urandom_range(0, 1) == 1;
            endcase
            out_ready = rdy;
            #1;
            check("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
            check("out_addr_y", 32'(addr_y), 32'(word));
            check("out_done_low", {31'b0, done}, 32'd0);
            check("out_wr_en_y", {31'b0, wr_en_y}, 32'd0);
            if (out_valid) check("y_data", {16'h0, y_dout}, 32'(yexp[word]));
            acc = out_valid && rdy;
            if (out_valid && !rdy) wait_cnt++;
            if (acc) begin
                word++;
                wait_cnt = 0;
            end
            exp_valid = !acc;
            budget++;
            @(negedge clk);
        end
        check("out_words", 32'(word), 32'(N));
        out_ready = 1'b0;
        #1;
        check("done_pulse", {31'b0, done}, 32'd1);
        check("done_out_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        #1;
        check("done_one_cycle", {31'b0, done}, 32'd0);
        check("idle_after_done", {31'b0, busy}, 32'd0);
    endtask

    task automatic set_basic();
        for (int i = 0; i < N; i++) xv[i] = i + 1;
        for (int i = 0; i < N * N; i++) av[i] = i + 1;
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;
`ifdef MVM_X_REUSE_EN
        reuse_x   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b1;
        #1;
        check_all_zero("reset");
        start    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_all_zero("post_reset");

        // Basic job, then the same data with backpressure and with input gaps.
        set_basic();
        run_job(1'b0, 0, 0, -1);
        run_job(1'b0, 0, 1, -1);
        run_job(1'b0, 1, 0, -1);

        // Reset while row 2 is being computed, then a fresh job.
        for (int i = 0; i < N; i++) xv[i] = rand_s8();
        for (int i = 0; i < N * N; i++) av[i] = rand_s8();
        run_job(1'b0, 0, 0, 2 * (N + 1));
        for (int i = 0; i < N; i++) xv[i] = 1;
        for (int i = 0; i < N * N; i++) av[i] = 2;
        run_job(1'b0, 0, 0, -1);

        // Signed extremes: the sum wraps at 16 bits.
        for (int i = 0; i < N; i++) xv[i] = -128;
        for (int i = 0; i < N * N; i++) av[i] = -128;
        run_job(1'b0, 0, 0, -1);
        for (int i = 0; i < N; i++) xv[i] = -1;
        for (int i = 0; i < N * N; i++) av[i] = (i < N) ? 127 : rand_s8();
        run_job(1'b0, 2, 2, -1);

`ifdef MVM_X_REUSE_EN
        // The second job reuses x and streams only the N*N A words.
        set_basic();
        run_job(1'b0, 0, 0, -1);
        for (int i = 0; i < N * N; i++) av[i] = 1;
        run_job(1'b1, 0, 0, -1);
`endif

        // Random data with random input gaps and random backpressure.
        for (int j = 0; j < 6; j++) begin
            for (int i = 0; i < N; i++) xv[i] = rand_s8();
            for (int i = 0; i < N * N; i++) av[i] = rand_s8();
            run_job(1'b0, 2, int'($urandom_range(0, 2)), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Watchdog, so the run always ends on its own.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
